// File: rtl/pixel_to_hex.sv
// Maps a pixel coordinate to a hexagonal sector (0..5) and a hexagonal distance
// from a configurable screen centre. The design is a fixed-latency pipeline with no backpressure.
module pixel_to_hex #(
  parameter int CX = 320,
  parameter int CY = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [2:0] rot,
  output logic       out_valid,
  output logic       out_sof,
  output logic [2:0] quadrant,
  output logic [9:0] radius
);

  localparam logic [11:0] CXV = 12'(CX);
  localparam logic [11:0] CYV = 12'(CY);

  // Input capture rank
  logic       v0, sof0;
  logic [9:0] x0, y0;
  logic [2:0] rot0, rot_reg, rot_mod;

  // Stage 1: centre-relative offsets
  logic       v1, sof1, dx_neg1, du_neg1;
  logic [9:0] ax1, ay1;
  logic [2:0] rot1;
  logic [11:0] dx_c, du_c;
  logic [9:0]  ax_c, ay_c;

  // Stage 2: raw sector and saturated radius
  logic       v2, sof2;
  logic [2:0] sect2, rot2, sect_c;
  logic [9:0] rad2, rad_c;
  logic [17:0] px_c, py_c;
  logic [18:0] sum_c;
  logic [11:0] raw_c;
  logic        steep_c;

  // Stage 3
  logic [3:0] qsum_c;
  logic [2:0] q_c;

  always_comb begin
    rot_mod = rot;
    if (rot >= 3'd6) rot_mod = rot - 3'd6;
  end

  // The start-of-frame pixel takes the freshly loaded rotation, not the stale register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0      <= 1'b0;
      sof0    <= 1'b0;
      x0      <= '0;
      y0      <= '0;
      rot0    <= '0;
      rot_reg <= '0;
    end else begin
      v0   <= in_valid;
      sof0 <= in_valid & in_sof;
      if (in_valid) begin
        x0   <= x;
        y0   <= y;
        rot0 <= in_sof ? rot_mod : rot_reg;
        if (in_sof) rot_reg <= rot_mod;
      end
    end
  end

  always_comb begin
    dx_c = {2'b00, x0} - CXV;
    du_c = CYV - {2'b00, y0};
    ax_c = dx_c[11] ? 10'(-dx_c) : dx_c[9:0];
    ay_c = du_c[11] ? 10'(-du_c) : du_c[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      sof1    <= 1'b0;
      dx_neg1 <= 1'b0;
      du_neg1 <= 1'b0;
      ax1     <= '0;
      ay1     <= '0;
      rot1    <= '0;
    end else begin
      v1   <= v0;
      sof1 <= sof0;
      if (v0) begin
        dx_neg1 <= dx_c[11];
        du_neg1 <= du_c[11];
        ax1     <= ax_c;
        ay1     <= ay_c;
        rot1    <= rot0;
      end
    end
  end

  // 111/64 approximates tan(60 deg); the non-steep radius blends ax and ay by 111/128 and 64/128.
  always_comb begin
    px_c    = 18'(ax1) * 18'd111;
    py_c    = {2'b00, ay1, 6'b000000};
    steep_c = py_c > px_c;
    sum_c   = {1'b0, px_c} + {1'b0, py_c};
    raw_c   = sum_c[18:7];
    rad_c   = (raw_c > 12'd1023) ? 10'd1023 : raw_c[9:0];
    if (steep_c) rad_c = ay1;
    if (!du_neg1) sect_c = steep_c ? 3'd1 : (dx_neg1 ? 3'd2 : 3'd0);
    else          sect_c = steep_c ? 3'd4 : (dx_neg1 ? 3'd3 : 3'd5);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sof2  <= 1'b0;
      sect2 <= '0;
      rad2  <= '0;
      rot2  <= '0;
    end else begin
      v2   <= v1;
      sof2 <= sof1;
      if (v1) begin
        sect2 <= sect_c;
        rad2  <= rad_c;
        rot2  <= rot1;
      end
    end
  end

  always_comb begin
    qsum_c = {1'b0, sect2} + {1'b0, rot2};
    q_c    = (qsum_c >= 4'd6) ? 3'(qsum_c - 4'd6) : qsum_c[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      quadrant  <= '0;
      radius    <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_sof  <= sof2;
        quadrant <= q_c;
        radius   <= rad2;
      end
    end
  end

endmodule

// File: tb/tb_pixel_to_hex.sv
// Scoreboard bench for pixel_to_hex: stimulus pushes expected results, a monitor pops and compares.
module tb_pixel_to_hex;

  localparam int CXP = 320;
  localparam int CYP = 240;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_sof;
  logic [9:0] x, y;
  logic [2:0] rot;
  logic       out_valid, out_sof;
  logic [2:0] quadrant;
  logic [9:0] radius;

  pixel_to_hex #(.CX(CXP), .CY(CYP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .x(x), .y(y), .rot(rot), .out_valid(out_valid), .out_sof(out_sof),
    .quadrant(quadrant), .radius(radius)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int sof;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rotm = 0;
  int   last_q = 0, last_r = 0, last_s = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference: hexagon geometry from plain integer arithmetic on centre offsets.
  task automatic ref_model(input int xx, input int yy, input int rm, output int q, output int r);
    int dx, du, ax, ay, sect;
    bit steep;
    dx = xx - CXP;
    du = CYP - yy;
    ax = (dx < 0) ? -dx : dx;
    ay = (du < 0) ? -du : du;
    steep = (ay * 64) > (ax * 111);
    if (du >= 0) sect = steep ? 1 : ((dx < 0) ? 2 : 0);
    else         sect = steep ? 4 : ((dx < 0) ? 3 : 5);
    r = steep ? ay : (ax * 111 + ay * 64) / 128;
    if (r > 1023) r = 1023;
    q = (sect + rm) % 6;
  endtask

  task automatic drive(input bit v, input bit s, input int xx, input int yy, input int rr,
                       input int qe, input int re, input bit model);
    int q, r;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    x        = 10'(xx);
    y        = 10'(yy);
    rot      = 3'(rr);
    q = qe;
    r = re;
    if (v) begin
      if (s) rotm = rr % 6;
      if (model) ref_model(xx, yy, rotm, q, r);
      sb.push_back('{q: q, r: r, sof: int'(s), due: cyc + 4});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk("quadrant", int'(quadrant), e.q);
          chk("radius", int'(radius), e.r);
          chk("out_sof", int'(out_sof), e.sof);
          chk("q_range", int'(quadrant <= 3'd5), 1);
          last_q = e.q;
          last_r = e.r;
          last_s = e.sof;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_out: out_valid=0 expected 1 (cycle %0d)", cyc);
          void'(sb.pop_front());
        end
        chk("hold", {int'(quadrant), int'(radius), int'(out_sof)} == {last_q, last_r, last_s} ? 1 : 0, 1);
      end
    end
  end

  initial begin
    int vpat[8];
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    x = '0;
    y = '0;
    rot = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quadrant", int'(quadrant), 0);
    chk("rst_radius", int'(radius), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    rst_n = 1'b1;

    // Directed single pixels, rot=0
    drive(1, 0, 320, 240, 0, 0, 0, 0);   idle(4);
    drive(1, 0, 420, 240, 0, 0, 86, 0);  idle(4);
    drive(1, 0, 320, 140, 0, 1, 100, 0); idle(4);
    drive(1, 0, 220, 240, 0, 2, 86, 0);  idle(4);
    drive(1, 0, 320, 340, 0, 4, 100, 0); idle(4);
    drive(1, 0, 0, 0, 0, 2, 397, 0);     idle(4);

    // Rotation loads only at start of frame, modulo 6
    drive(1, 1, 420, 240, 2, 2, 86, 0);
    drive(1, 0, 420, 240, 0, 2, 86, 0);
    drive(1, 1, 420, 240, 7, 1, 86, 0);
    idle(4);

    // Bubble pattern propagates unchanged
    vpat = '{1, 0, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 8; i++)
      drive(vpat[i][0], i == 0, 100 + 50 * i, 30 * i, 3, 0, 0, 1);
    idle(5);

    // Boundary corners
    drive(1, 0, 1023, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 1023, 0, 0, 0, 1);
    drive(1, 0, 1023, 1023, 0, 0, 0, 1);
    idle(4);

    // Reset with two pixels in flight
    drive(1, 0, 420, 240, 0, 0, 0, 1);
    drive(1, 0, 320, 140, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    sb.delete();
    rotm = 0;
    last_q = 0;
    last_r = 0;
    last_s = 0;
    @(negedge clk);
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_quadrant", int'(quadrant), 0);
    chk("rst2_radius", int'(radius), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    chk("post_rst_quadrant", int'(quadrant), 0);
    chk("post_rst_radius", int'(radius), 0);
    drive(1, 0, 320, 140, 5, 1, 100, 0);
    idle(4);

    // Random traffic with bubbles, sporadic frame starts and mid-frame rot noise
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 7), 0, 0, 1);
    idle(4);

    // Subsampled 640x480 frame
    for (int yy = 0; yy < 480; yy += 4)
      for (int xx = 0; xx < 640; xx += 4)
        drive(1, (xx == 0) && (yy == 0), xx, yy, $urandom_range(0, 7), 0, 0, 1);
    idle(1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding expected 0", sb.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
